ysyx_23060077_issue_ctrl: RTL and testbench

- Sits between the decode stage and the EXU. Holds one decoded instruction in an output stage register.
- Keeps a per-register busy scoreboard and stalls decode on RAW/WAW hazards against in-flight writes.
- Caps the number of in-flight instructions, clears all uncommitted state on flush, and releases the scoreboard on writeback.
- Sequences every decoded instruction into the shared EXU/LSU datapath through valid/ready handshakes.

---
 rtl/ysyx_23060077_issue_ctrl_pkg.sv | 13 +
 rtl/ysyx_23060077_scoreboard.sv | 73 +++++++
 rtl/ysyx_23060077_issue_ctrl.sv | 123 ++++++++++++
 tb/tb_ysyx_23060077_issue_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060077_issue_ctrl_pkg.sv
// Shared sizing defaults for the issue controller and its scoreboard.
package ysyx_23060077_issue_ctrl_pkg;

    localparam int unsigned REG_W_DEF        = 5;
    localparam int unsigned NREG_DEF         = 32;
    localparam int unsigned PAYLOAD_W_DEF    = 128;
    localparam int unsigned MAX_INFLIGHT_DEF = 4;

    function automatic int unsigned cnt_width(input int unsigned max_inflight);
        return $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/ysyx_23060077_scoreboard.sv
// Per-register busy vector. Optional macro YSYX_23060077_ISSUE_WB_BYPASS_EN hides a busy bit
// in the very cycle its writeback clear arrives.
module ysyx_23060077_scoreboard
    import ysyx_23060077_issue_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = REG_W_DEF,
    parameter int unsigned NREG  = NREG_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_set_en,
    input  logic [REG_W-1:0] i_set_idx,
    input  logic             i_clr_en,
    input  logic [REG_W-1:0] i_clr_idx,
    input  logic             i_fclr_en,
    input  logic [REG_W-1:0] i_fclr_idx,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    input  logic [REG_W-1:0] i_rd,
    output logic             o_busy_rs1,
    output logic             o_busy_rs2,
    output logic             o_busy_rd
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_fclr_mask;
    logic [NREG-1:0] w_busy_eff;
    logic [NREG-1:0] w_busy_d;

    // Loops start at 1 so x0 can never be marked or reported busy.
    always_comb begin
        w_set_mask  = '0;
        w_clr_mask  = '0;
        w_fclr_mask = '0;
        for (int r = 1; r < NREG; r++) begin
            w_set_mask[r]  = i_set_en  && (i_set_idx  == REG_W'(r));
            w_clr_mask[r]  = i_clr_en  && (i_clr_idx  == REG_W'(r));
            w_fclr_mask[r] = i_fclr_en && (i_fclr_idx == REG_W'(r));
        end
    end

    // A new writer on a retiring register keeps it busy.
    always_comb begin
        w_busy_d = (r_busy & ~w_clr_mask & ~w_fclr_mask) | w_set_mask;
`ifdef YSYX_23060077_ISSUE_WB_BYPASS_EN
        w_busy_eff = r_busy & ~w_clr_mask;
`else
        w_busy_eff = r_busy;
`endif
    end

    always_comb begin
        o_busy_rs1 = 1'b0;
        o_busy_rs2 = 1'b0;
        o_busy_rd  = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (i_rs1 == REG_W'(r)) o_busy_rs1 = w_busy_eff[r];
            if (i_rs2 == REG_W'(r)) o_busy_rs2 = w_busy_eff[r];
            if (i_rd  == REG_W'(r)) o_busy_rd  = w_busy_eff[r];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_d;
        end
    end

endmodule

// File: rtl/ysyx_23060077_issue_ctrl.sv
// Decode-to-EXU issue stage: one staged instruction, RAW/WAW scoreboard, in-flight cap.
// Optional macro YSYX_23060077_ISSUE_WB_BYPASS_EN lets dependents issue in the writeback cycle.
module ysyx_23060077_issue_ctrl
    import ysyx_23060077_issue_ctrl_pkg::*;
#(
    parameter int unsigned REG_W        = REG_W_DEF,
    parameter int unsigned NREG         = NREG_DEF,
    parameter int unsigned PAYLOAD_W    = PAYLOAD_W_DEF,
    parameter int unsigned MAX_INFLIGHT = MAX_INFLIGHT_DEF,
    localparam int unsigned CNT_W       = cnt_width(MAX_INFLIGHT)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [REG_W-1:0]     id_rs1,
    input  logic [REG_W-1:0]     id_rs2,
    input  logic [REG_W-1:0]     id_rd,
    input  logic [PAYLOAD_W-1:0] id_payload,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [REG_W-1:0]     ex_rd,
    output logic [PAYLOAD_W-1:0] ex_payload,
    input  logic                 wb_valid,
    input  logic [REG_W-1:0]     wb_rd,
    output logic [CNT_W-1:0]     inflight_cnt,
    output logic                 hazard_stall
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic                 r_ex_valid;
    logic [REG_W-1:0]     r_ex_rd;
    logic [PAYLOAD_W-1:0] r_ex_payload;
    logic [CNT_W-1:0]     r_cnt;

    logic             w_busy_rs1;
    logic             w_busy_rs2;
    logic             w_busy_rd;
    logic             w_hazard;
    logic             w_stage_free;
    logic             w_cap_ok;
    logic             w_accept;
    logic             w_issue;
    logic             w_wb_dec;
    logic             w_fclr_en;
    logic [SUM_W-1:0] w_occupancy;
    logic [CNT_W-1:0] w_cnt_d;

    ysyx_23060077_scoreboard #(
        .REG_W (REG_W),
        .NREG  (NREG)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .i_set_en   (w_accept),
        .i_set_idx  (id_rd),
        .i_clr_en   (wb_valid),
        .i_clr_idx  (wb_rd),
        .i_fclr_en  (w_fclr_en),
        .i_fclr_idx (r_ex_rd),
        .i_rs1      (id_rs1),
        .i_rs2      (id_rs2),
        .i_rd       (id_rd),
        .o_busy_rs1 (w_busy_rs1),
        .o_busy_rs2 (w_busy_rs2),
        .o_busy_rd  (w_busy_rd)
    );

    // Occupancy counts the staged instruction too, so the cap holds once it issues.
    always_comb begin
        w_hazard     = w_busy_rs1 | w_busy_rs2 | w_busy_rd;
        w_stage_free = ~r_ex_valid | ex_ready;
        w_occupancy  = SUM_W'(r_cnt) + SUM_W'(r_ex_valid);
        w_cap_ok     = w_occupancy < SUM_W'(MAX_INFLIGHT);
        id_ready     = w_stage_free & ~w_hazard & w_cap_ok & ~flush;
        w_accept     = id_valid & id_ready;
        w_issue      = r_ex_valid & ex_ready;
        w_wb_dec     = wb_valid & (r_cnt != '0);
        w_fclr_en    = flush & r_ex_valid & ~ex_ready;
        hazard_stall = id_valid & w_hazard;
        ex_valid     = r_ex_valid;
        ex_rd        = r_ex_rd;
        ex_payload   = r_ex_payload;
        inflight_cnt = r_cnt;
    end

    always_comb begin
        w_cnt_d = r_cnt;
        if (w_issue && !w_wb_dec) begin
            w_cnt_d = r_cnt + CNT_W'(1);
        end else if (!w_issue && w_wb_dec) begin
            w_cnt_d = r_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ex_valid   <= 1'b0;
            r_ex_rd      <= '0;
            r_ex_payload <= '0;
            r_cnt        <= '0;
        end else begin
            if (flush) begin
                r_ex_valid <= 1'b0;
            end else if (w_accept) begin
                r_ex_valid   <= 1'b1;
                r_ex_rd      <= id_rd;
                r_ex_payload <= id_payload;
            end else if (w_issue) begin
                r_ex_valid <= 1'b0;
            end
            r_cnt <= w_cnt_d;
        end
    end

`ifndef SYNTHESIS
    wb_without_inflight: assert property (@(posedge clock) disable iff (reset)
        !(wb_valid && r_cnt == '0));
`endif

endmodule

// File: tb/tb_ysyx_23060077_issue_ctrl.sv
// Directed bench for the issue controller; issued instructions are checked by a queue monitor.
module tb_ysyx_23060077_issue_ctrl;

`ifdef YSYX_23060077_ISSUE_WB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif

    typedef struct packed {
        logic [4:0]   rd;
        logic [127:0] pl;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset;
    logic         flush;
    logic         id_valid;
    logic         id_ready;
    logic [4:0]   id_rs1;
    logic [4:0]   id_rs2;
    logic [4:0]   id_rd;
    logic [127:0] id_payload;
    logic         ex_valid;
    logic         ex_ready;
    logic [4:0]   ex_rd;
    logic [127:0] ex_payload;
    logic         wb_valid;
    logic [4:0]   wb_rd;
    logic [2:0]   inflight_cnt;
    logic         hazard_stall;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    ysyx_23060077_issue_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .id_payload   (id_payload),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_rd        (ex_rd),
        .ex_payload   (ex_payload),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .inflight_cnt (inflight_cnt),
        .hazard_stall (hazard_stall)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [127:0] mkpl(input int n);
        return {4{32'hC0DE_0000 + 32'(n)}};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Holds the instruction until accepted; the expected issue is queued at acceptance.
    task automatic send(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [127:0] pl, output int acc_cyc);
        bit done = 1'b0;
        acc_cyc    = -1;
        id_valid   = 1'b1;
        id_rs1     = rs1;
        id_rs2     = rs2;
        id_rd      = rd;
        id_payload = pl;
        for (int i = 0; i < 40 && !done; i++) begin
            #2;
            if (id_ready) begin
                exp_q.push_back('{rd: rd, pl: pl});
                acc_cyc = cyc;
                done    = 1'b1;
            end
            @(posedge clock);
            #1;
        end
        id_valid = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept rd=%0d", rd);
        end
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1'b1;
        wb_rd    = rd;
        step();
        wb_valid = 1'b0;
        wb_rd    = '0;
    endtask

    always @(negedge clock) begin
        if (!reset && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: got rd=%0d expected none", ex_rd);
            end else begin
                mon_e = exp_q.pop_front();
                chk("issue_rd", 128'(ex_rd), 128'(mon_e.rd));
                chk("issue_payload", ex_payload, mon_e.pl);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc2;
        int wbc;
        int relc;
        int st;
        reset = 1'b1; flush = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_payload = '0; ex_ready = 1'b0; wb_valid = 1'b0; wb_rd = '0;
        step(); step();
        reset = 1'b0;
        #2;
        chk("rst_ex_valid", 128'(ex_valid), 128'(0));
        chk("rst_ex_rd", 128'(ex_rd), 128'(0));
        chk("rst_ex_payload", ex_payload, 128'(0));
        chk("rst_inflight", 128'(inflight_cnt), 128'(0));
        chk("rst_hazard_stall", 128'(hazard_stall), 128'(0));
        chk("rst_busy", 128'(dut.u_scoreboard.r_busy), 128'(0));
        step();

        // Basic accept/issue/writeback.
        ex_ready = 1'b1;
        st = cyc;
        send(5'd1, 5'd2, 5'd3, mkpl(1), acc);
        chk("t1_accept_immediate", 128'(acc - st), 128'(0));
        #2;
        chk("t1_ex_valid", 128'(ex_valid), 128'(1));
        chk("t1_busy3_set", 128'(dut.u_scoreboard.r_busy[3]), 128'(1));
        chk("t1_inflight_pre_issue", 128'(inflight_cnt), 128'(0));
        step(); #2;
        chk("t1_ex_valid_drop", 128'(ex_valid), 128'(0));
        chk("t1_inflight_issued", 128'(inflight_cnt), 128'(1));
        wb(5'd3); #2;
        chk("t1_inflight_wb", 128'(inflight_cnt), 128'(0));
        chk("t1_busy3_clr", 128'(dut.u_scoreboard.r_busy[3]), 128'(0));
        step();

        // RAW stall released by writeback.
        send(5'd0, 5'd0, 5'd5, mkpl(2), acc);
        fork
            send(5'd5, 5'd0, 5'd6, mkpl(3), acc2);
            begin
                #2;
                chk("raw_stall", 128'(hazard_stall), 128'(1));
                chk("raw_ready_low", 128'(id_ready), 128'(0));
                step(); #1;
                wb_valid = 1'b1; wb_rd = 5'd5; wbc = cyc;
                #1;
                chk("raw_stall_wb_cycle", 128'(hazard_stall), 128'(1 - BYP));
                step();
                wb_valid = 1'b0; wb_rd = '0;
            end
        join
        chk("raw_issue_latency", 128'(acc2 - wbc), 128'(1 - BYP));
        step(); step(); #2;
        chk("raw_dep_busy6", 128'(dut.u_scoreboard.r_busy[6]), 128'(1));
        wb(5'd6); #2;
        chk("raw_inflight_zero", 128'(inflight_cnt), 128'(0));
        step();

        // Backpressure hold, then issue and accept in the same cycle.
        ex_ready = 1'b0;
        send(5'd0, 5'd0, 5'd0, mkpl(4), acc);
        fork
            send(5'd0, 5'd0, 5'd0, mkpl(5), acc2);
            begin
                for (int i = 0; i < 3; i++) begin
                    #2;
                    chk("bp_hold_payload", ex_payload, mkpl(4));
                    chk("bp_ready_low", 128'(id_ready), 128'(0));
                    step();
                end
                #1;
                ex_ready = 1'b1; relc = cyc;
            end
        join
        chk("bp_accept_on_release", 128'(acc2 - relc), 128'(0));
        #2;
        chk("bp_next_staged", ex_payload, mkpl(5));
        step(); #2;
        chk("bp_inflight", 128'(inflight_cnt), 128'(2));
        wb(5'd0); wb(5'd0); #2;
        chk("bp_inflight_zero", 128'(inflight_cnt), 128'(0));
        step();

        // In-flight cap.
        for (int i = 0; i < 4; i++) send(5'd0, 5'd0, 5'd0, mkpl(6 + i), acc);
        fork
            send(5'd0, 5'd0, 5'd0, mkpl(10), acc2);
            begin
                #2;
                chk("cap_block_staged", 128'(id_ready), 128'(0));
                step(); #2;
                chk("cap_block_full", 128'(id_ready), 128'(0));
                chk("cap_cnt_full", 128'(inflight_cnt), 128'(4));
                step(); #1;
                wb_valid = 1'b1; wb_rd = '0; wbc = cyc;
                #1;
                chk("cap_block_wb_cycle", 128'(id_ready), 128'(0));
                step();
                wb_valid = 1'b0;
            end
        join
        chk("cap_accept_after_wb", 128'(acc2 - wbc), 128'(1));
        step(); #2;
        chk("cap_cnt_refill", 128'(inflight_cnt), 128'(4));
        for (int i = 0; i < 4; i++) wb(5'd0);
        #2;
        chk("cap_inflight_zero", 128'(inflight_cnt), 128'(0));
        step();

        // Flush of an unissued staged instruction.
        ex_ready = 1'b0;
        send(5'd0, 5'd0, 5'd7, mkpl(11), acc);
        #2;
        chk("flush_busy7_pre", 128'(dut.u_scoreboard.r_busy[7]), 128'(1));
        flush = 1'b1;
        void'(exp_q.pop_back());
        step();
        flush = 1'b0;
        #2;
        chk("flush_kill", 128'(ex_valid), 128'(0));
        chk("flush_busy7_clr", 128'(dut.u_scoreboard.r_busy[7]), 128'(0));
        chk("flush_cnt_same", 128'(inflight_cnt), 128'(0));
        flush = 1'b1; #1;
        chk("flush_blocks_ready", 128'(id_ready), 128'(0));
        flush = 1'b0; #1;
        chk("ready_after_flush", 128'(id_ready), 128'(1));
        step();

        // Flush in the same cycle the staged instruction issues.
        ex_ready = 1'b1;
        send(5'd0, 5'd0, 5'd8, mkpl(12), acc);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #2;
        chk("flush_issue_kill", 128'(ex_valid), 128'(0));
        chk("flush_issue_counted", 128'(inflight_cnt), 128'(1));
        chk("flush_issue_busy8", 128'(dut.u_scoreboard.r_busy[8]), 128'(1));
        wb(5'd8); #2;
        chk("flush_issue_busy8_clr", 128'(dut.u_scoreboard.r_busy[8]), 128'(0));
        chk("flush_issue_cnt_zero", 128'(inflight_cnt), 128'(0));
        step();

        // x0 never busy; WAW stall on rd.
        ex_ready = 1'b0;
        send(5'd0, 5'd0, 5'd0, mkpl(13), acc);
        id_valid = 1'b1; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        #2;
        chk("x0_no_stall", 128'(hazard_stall), 128'(0));
        chk("x0_never_busy", 128'(dut.u_scoreboard.r_busy[0]), 128'(0));
        id_valid = 1'b0;
        ex_ready = 1'b1;
        step();
        send(5'd0, 5'd0, 5'd9, mkpl(14), acc);
        fork
            send(5'd0, 5'd0, 5'd9, mkpl(15), acc2);
            begin
                #2;
                chk("waw_stall", 128'(hazard_stall), 128'(1));
                step(); #1;
                wb_valid = 1'b1; wb_rd = 5'd9; wbc = cyc;
                step();
                wb_valid = 1'b0; wb_rd = '0;
            end
        join
        chk("waw_issue_latency", 128'(acc2 - wbc), 128'(1 - BYP));
        step(); #2;
        chk("waw_busy9_reset", 128'(dut.u_scoreboard.r_busy[9]), 128'(1));
        wb(5'd9); wb(5'd0); #2;
        chk("final_inflight_zero", 128'(inflight_cnt), 128'(0));
        step(); step();
        chk("queue_drained", 128'(exp_q.size()), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
